adc_bcd_conv: RTL and testbench

- Downstream of the SPI ADC reader and upstream of the 7-segment display driver.
- Accepts 12-bit ADC samples on a one-cycle valid strobe and averages 2^AVG_LOG2 of them.
- Converts the average to four BCD digits with a sequential double-dabble.
- Holds the digits stable for the display driver until the next conversion completes.

---
 rtl/adc_bcd_conv.sv | 161 ++++++++++++++++
 tb/tb_adc_bcd_conv.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_bcd_conv.sv
// ============================================================================
// Module   : adc_bcd_conv
// Purpose  : Averages 2^AVG_LOG2 ADC samples, then converts the average to
//            four BCD digits with a sequential double-dabble.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_bcd_conv #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic [3:0]        ones,
    output logic [3:0]        tens,
    output logic [3:0]        hundreds,
    output logic [3:0]        thousands,
    output logic              bcd_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SR_W  = 16 + DATA_W;
    localparam int IT_W  = 4;
    localparam logic [IT_W-1:0] C_LAST_IT = IT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_CONV  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [IT_W-1:0]   r_iter;
    logic [SR_W-1:0]   r_sr;
    logic [3:0]        r_ones;
    logic [3:0]        r_tens;
    logic [3:0]        r_hundreds;
    logic [3:0]        r_thousands;
    logic              r_bcd_valid;
    logic              r_busy;
    logic              r_overrun;

    logic              w_accept;
    logic              w_last_sample;
    logic              w_last_iter;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_avg;
    logic [SR_W-1:0]   w_adj;

    assign w_accept    = data_valid && !r_busy;
    assign w_sum       = r_acc + ACC_W'(data_in);
    assign w_avg       = DATA_W'(w_sum >> AVG_LOG2);
    assign w_last_iter = (r_iter == C_LAST_IT);

    generate
        if (AVG_LOG2 == 0) begin : g_no_avg
            assign w_last_sample = 1'b1;
        end else begin : g_avg
            assign w_last_sample = (r_cnt == {CNT_W{1'b1}});
        end
    endgenerate

    // Double-dabble correction: BCD nibbles sit above the binary field.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_adj
            logic [3:0] w_nib;
            assign w_nib = r_sr[DATA_W + 4*i +: 4];
            assign w_adj[DATA_W + 4*i +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
        end
    endgenerate
    assign w_adj[DATA_W-1:0] = r_sr[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && w_last_sample) w_next = ST_CONV;
            ST_CONV:  if (w_last_iter)               w_next = ST_DONE;
            ST_DONE:                                 w_next = ST_ACCUM;
            default:                                 w_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_iter      <= '0;
            r_sr        <= '0;
            r_ones      <= '0;
            r_tens      <= '0;
            r_hundreds  <= '0;
            r_thousands <= '0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            if (data_valid && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last_sample) begin
                            r_sr   <= {16'd0, w_avg};
                            r_acc  <= '0;
                            r_cnt  <= '0;
                            r_iter <= '0;
                            r_busy <= 1'b1;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_CONV: begin
                    r_sr   <= w_adj << 1;
                    r_iter <= r_iter + IT_W'(1);
                end
                ST_DONE: begin
                    r_ones      <= r_sr[DATA_W      +: 4];
                    r_tens      <= r_sr[DATA_W + 4  +: 4];
                    r_hundreds  <= r_sr[DATA_W + 8  +: 4];
                    r_thousands <= r_sr[DATA_W + 12 +: 4];
                    r_bcd_valid <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ones      = r_ones;
    assign tens      = r_tens;
    assign hundreds  = r_hundreds;
    assign thousands = r_thousands;
    assign bcd_valid = r_bcd_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_adc_bcd_conv.sv
// ============================================================================
// Module   : tb_adc_bcd_conv
// Purpose  : Scoreboard bench for adc_bcd_conv (one instance with no
//            averaging, one averaging four samples).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic [11:0] data0, data2;
    logic        valid0, valid2;
    logic [3:0]  ones0, tens0, hund0, thou0;
    logic [3:0]  ones2, tens2, hund2, thou2;
    logic        bcd_valid0, busy0, overrun0;
    logic        bcd_valid2, busy2, overrun2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] q0[$];
    logic [15:0] q2[$];

    wire [15:0] dig0 = {thou0, hund0, tens0, ones0};
    wire [15:0] dig2 = {thou2, hund2, tens2, ones2};

    adc_bcd_conv #(.DATA_W(12), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data0), .data_valid(valid0),
        .ones(ones0), .tens(tens0), .hundreds(hund0), .thousands(thou0),
        .bcd_valid(bcd_valid0), .busy(busy0), .overrun(overrun0)
    );

    adc_bcd_conv #(.DATA_W(12), .AVG_LOG2(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data2), .data_valid(valid2),
        .ones(ones2), .tens(tens2), .hundreds(hund2), .thousands(thou2),
        .bcd_valid(bcd_valid2), .busy(busy2), .overrun(overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Scoreboard: every digit update must match the oldest outstanding result.
    always @(negedge clk) begin
        logic [15:0] exp_d;
        if (rst_n && bcd_valid0) begin
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL dut0_unexpected_valid got=%h expected no update", dig0);
            end else begin
                exp_d = q0.pop_front();
                if (dig0 !== exp_d) begin
                    n_fail++;
                    $display("FAIL dut0_digits got=%h expected=%h", dig0, exp_d);
                end
            end
        end
        if (rst_n && bcd_valid2) begin
            n_tests++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL dut2_unexpected_valid got=%h expected no update", dig2);
            end else begin
                exp_d = q2.pop_front();
                if (dig2 !== exp_d) begin
                    n_fail++;
                    $display("FAIL dut2_digits got=%h expected=%h", dig2, exp_d);
                end
            end
        end
    end

    // Drivers are called at #1 after a rising edge; they return #1 after the accepting edge.
    task automatic drive0(input int v);
        data0  = 12'(v);
        valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
    endtask

    task automatic drive2(input int v);
        data2  = 12'(v);
        valid2 = 1'b1;
        @(posedge clk);
        #1 valid2 = 1'b0;
    endtask

    task automatic wait_valid(input bit which, input int maxc, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if ((which ? bcd_valid2 : bcd_valid0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout got=no bcd_valid expected=pulse within %0d cycles", name, maxc);
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({dig0, bcd_valid0, busy0, overrun0, dig2, bcd_valid2, busy2, overrun2} !== '0) begin
            n_fail++;
            $display("FAIL %s got=%h/%b%b%b %h/%b%b%b expected=all zero", name,
                     dig0, bcd_valid0, busy0, overrun0, dig2, bcd_valid2, busy2, overrun2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        q0.push_back(to_bcd(1234));
        drive0(1234);
        n_tests++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL single_busy_start got=%b expected=1", busy0); end
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (bcd_valid0 !== 1'b0 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_early got valid=%b busy=%b expected valid=0 busy=1", bcd_valid0, busy0);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bcd_valid0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency got valid=%b busy=%b expected valid=1 busy=0", bcd_valid0, busy0);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bcd_valid0 !== 1'b0 || dig0 !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_pulse_hold got valid=%b digits=%h expected valid=0 digits=1234", bcd_valid0, dig0);
        end
    endtask

    task automatic test_full_scale();
        q0.push_back(to_bcd(4095));
        drive0(4095);
        wait_valid(1'b0, 20, "full_scale");
        q0.push_back(to_bcd(0));
        drive0(0);
        wait_valid(1'b0, 20, "zero");
    endtask

    task automatic test_averaging();
        q2.push_back(to_bcd((100 + 101 + 102 + 103) >> 2));
        drive2(100); drive2(101); drive2(102);
        n_tests++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL avg_busy_partial got=%b expected=0", busy2); end
        drive2(103);
        n_tests++;
        if (busy2 !== 1'b1) begin n_fail++; $display("FAIL avg_busy_fourth got=%b expected=1", busy2); end
        wait_valid(1'b1, 20, "avg_101");
        q2.push_back(to_bcd((4 * 4095) >> 2));
        for (int i = 0; i < 4; i++) drive2(4095);
        wait_valid(1'b1, 20, "avg_4095");
    endtask

    task automatic test_boundary();
        q0.push_back(to_bcd(7));
        drive0(7);
        wait_valid(1'b0, 20, "boundary_first");
        q0.push_back(to_bcd(8));
        drive0(8);
        n_tests++;
        if (busy0 !== 1'b1 || overrun0 !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_accept got busy=%b overrun=%b expected busy=1 overrun=0", busy0, overrun0);
        end
        wait_valid(1'b0, 20, "boundary_second");
    endtask

    task automatic test_drop();
        q2.push_back(to_bcd((10 + 20 + 30 + 40) >> 2));
        drive2(10); drive2(20); drive2(30); drive2(40);
        repeat (4) @(posedge clk);
        #1;
        drive2(999);
        n_tests++;
        if (overrun2 !== 1'b1 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_overrun got overrun=%b busy=%b expected overrun=1 busy=1", overrun2, busy2);
        end
        wait_valid(1'b1, 20, "drop_first");
        q2.push_back(to_bcd((50 + 60 + 70 + 80) >> 2));
        drive2(50); drive2(60); drive2(70); drive2(80);
        wait_valid(1'b1, 20, "drop_second");
        n_tests++;
        if (overrun2 !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got=%b expected=1", overrun2); end
    endtask

    task automatic test_reset_mid();
        drive0(4095);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        q0.delete();
        q2.delete();
        #2;
        check_zero("reset_mid_async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bcd_valid0 !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL reset_mid_no_valid got=%b expected=0", bcd_valid0);
                break;
            end
        end
        check_zero("reset_mid_idle");
        q0.push_back(to_bcd(42));
        drive0(42);
        wait_valid(1'b0, 20, "restart_42");
        n_tests++;
        if (dig0 !== 16'h0042) begin n_fail++; $display("FAIL restart_digits got=%h expected=0042", dig0); end
    endtask

    initial begin
        data0 = '0; data2 = '0; valid0 = 1'b0; valid2 = 1'b0;
        test_reset();
        test_single();
        test_full_scale();
        test_averaging();
        test_boundary();
        test_drop();
        test_reset_mid();
        repeat (3) @(posedge clk);
        n_tests++;
        if (q0.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d/%0d pending expected=0/0", q0.size(), q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
